// File: rtl/gte_mac_accum.sv
// Single-lane GTE multiply-accumulate with overflow detection, optional >>12 shift and IR clamp.
// Terms accumulate into a wrapping 44-bit register; the last term triggers a one-cycle output stage.
module gte_mac_accum #(
    parameter int unsigned PROD_W = 35,
    parameter int unsigned ACC_W  = 44,
    parameter int unsigned OUT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [PROD_W-1:0] i_product,
    input  logic              i_clear,
    input  logic              i_negate,
    input  logic              i_last,
    input  logic              i_sf,
    input  logic              i_lm,
    input  logic              i_flagClr,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_mac,
    output logic [15:0]       o_ir,
    output logic              o_macOvfPos,
    output logic              o_macOvfNeg,
    output logic              o_irSat
);

    localparam int unsigned IR_W     = 16;
    localparam int unsigned SF_SHIFT = 12;
    localparam logic signed [ACC_W-1:0] IR_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] IR_LO = ACC_W'(-32768);

    logic signed [ACC_W-1:0] acc;
    logic                    pend;

    logic signed [ACC_W:0]   prod_ext_c;
    logic signed [ACC_W:0]   term_c;
    logic signed [ACC_W:0]   base_c;
    logic signed [ACC_W:0]   sum_c;
    logic                    ovf_pos_c;
    logic                    ovf_neg_c;

    logic signed [ACC_W-1:0] shifted_c;
    logic signed [ACC_W-1:0] lo_c;
    logic [IR_W-1:0]         ir_c;
    logic                    sat_c;

    // Accumulate stage: one guard bit above the accumulator exposes overflow in either direction.
    always_comb begin
        prod_ext_c = (ACC_W+1)'($signed(i_product));
        term_c     = i_negate ? -prod_ext_c : prod_ext_c;
        base_c     = i_clear ? '0 : {acc[ACC_W-1], acc};
        sum_c      = base_c + term_c;
        ovf_pos_c  = i_valid & ~sum_c[ACC_W] &  sum_c[ACC_W-1];
        ovf_neg_c  = i_valid &  sum_c[ACC_W] & ~sum_c[ACC_W-1];
    end

    // Output stage: works on the accumulator committed by the last term, so a new term may overlap.
    always_comb begin
        shifted_c = i_sf ? (acc >>> SF_SHIFT) : acc;
        lo_c      = i_lm ? '0 : IR_LO;
        ir_c      = shifted_c[IR_W-1:0];
        sat_c     = 1'b0;
        if (shifted_c > IR_HI) begin
            ir_c  = IR_HI[IR_W-1:0];
            sat_c = pend;
        end else if (shifted_c < lo_c) begin
            ir_c  = lo_c[IR_W-1:0];
            sat_c = pend;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= '0;
            pend        <= 1'b0;
            o_valid     <= 1'b0;
            o_mac       <= '0;
            o_ir        <= '0;
            o_macOvfPos <= 1'b0;
            o_macOvfNeg <= 1'b0;
            o_irSat     <= 1'b0;
        end else begin
            if (i_valid) begin
                acc <= sum_c[ACC_W-1:0];
            end
            pend    <= i_valid & i_last;
            o_valid <= pend;
            if (pend) begin
                o_mac <= shifted_c[OUT_W-1:0];
                o_ir  <= ir_c;
            end
            // A set condition overrides a simultaneous clear.
            o_macOvfPos <= ovf_pos_c | (o_macOvfPos & ~i_flagClr);
            o_macOvfNeg <= ovf_neg_c | (o_macOvfNeg & ~i_flagClr);
            o_irSat     <= sat_c     | (o_irSat     & ~i_flagClr);
        end
    end

endmodule

// File: tb/tb_gte_mac_accum.sv
// Self-checking bench for gte_mac_accum: directed scenarios plus random commands against
// an arithmetic model of the MAC/IR rules.
module tb_gte_mac_accum;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [34:0] i_product;
    logic        i_clear;
    logic        i_negate;
    logic        i_last;
    logic        i_sf;
    logic        i_lm;
    logic        i_flagClr;
    logic        o_valid;
    logic [31:0] o_mac;
    logic [15:0] o_ir;
    logic        o_macOvfPos;
    logic        o_macOvfNeg;
    logic        o_irSat;

    int n_checks = 0;
    int n_errors = 0;

    localparam longint ACC_MAX = (64'sd1 <<< 43) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< 43);

    // Reference model state
    longint             m_acc;
    bit                 m_pend;
    bit                 m_valid;
    logic signed [31:0] m_mac;
    logic signed [15:0] m_ir;
    bit                 m_pos, m_neg, m_sat;

    gte_mac_accum dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_product(i_product),
        .i_clear(i_clear), .i_negate(i_negate), .i_last(i_last), .i_sf(i_sf),
        .i_lm(i_lm), .i_flagClr(i_flagClr), .o_valid(o_valid), .o_mac(o_mac),
        .o_ir(o_ir), .o_macOvfPos(o_macOvfPos), .o_macOvfNeg(o_macOvfNeg), .o_irSat(o_irSat)
    );

    always #5 i_clk = ~i_clk;

    function automatic longint wrap_acc(input longint v);
        logic signed [43:0] t;
        t = v[43:0];
        return longint'(t);
    endfunction

    // Drive one cycle of inputs, advance the model by the same clock edge, then settle.
    task automatic step(input bit v, input longint prod, input bit clr, input bit neg,
                        input bit last, input bit sf, input bit lm, input bit fclr);
        longint term, sum, sh, lo, irv;
        bit pos_s, neg_s, sat_s;
        i_rst = 1'b0; i_valid = v; i_product = prod[34:0]; i_clear = clr;
        i_negate = neg; i_last = last; i_sf = sf; i_lm = lm; i_flagClr = fclr;
        pos_s = 0; neg_s = 0; sat_s = 0;
        m_valid = m_pend;
        if (m_pend) begin
            sh  = sf ? (m_acc >>> 12) : m_acc;
            lo  = lm ? 0 : -32768;
            irv = sh;
            if (sh > 32767) begin irv = 32767; sat_s = 1; end
            else if (sh < lo) begin irv = lo; sat_s = 1; end
            m_mac = sh[31:0];
            m_ir  = irv[15:0];
        end
        if (v) begin
            term  = neg ? -prod : prod;
            sum   = (clr ? 0 : m_acc) + term;
            pos_s = sum > ACC_MAX;
            neg_s = sum < ACC_MIN;
            m_acc = wrap_acc(sum);
        end
        m_pend = v && last;
        m_pos = pos_s || (m_pos && !fclr);
        m_neg = neg_s || (m_neg && !fclr);
        m_sat = sat_s || (m_sat && !fclr);
        @(posedge i_clk); #1;
    endtask

    task automatic apply_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_product = '0; i_clear = 0; i_negate = 0;
        i_last = 0; i_sf = 0; i_lm = 0; i_flagClr = 0;
        m_acc = 0; m_pend = 0; m_valid = 0; m_mac = 0; m_ir = 0;
        m_pos = 0; m_neg = 0; m_sat = 0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 6;
        if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%0b want=0", o_valid); end
        if (o_mac !== 32'd0) begin n_errors++; $display("FAIL reset_mac got=%0h want=0", o_mac); end
        if (o_ir !== 16'd0) begin n_errors++; $display("FAIL reset_ir got=%0h want=0", o_ir); end
        if (o_macOvfPos !== 1'b0) begin n_errors++; $display("FAIL reset_pos got=%0b want=0", o_macOvfPos); end
        if (o_macOvfNeg !== 1'b0) begin n_errors++; $display("FAIL reset_neg got=%0b want=0", o_macOvfNeg); end
        if (o_irSat !== 1'b0) begin n_errors++; $display("FAIL reset_sat got=%0b want=0", o_irSat); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            step(0, longint'($urandom_range(0, 32'h7fff_ffff)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            n_checks += 3;
            if (o_valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid cyc=%0d got=%0b want=0", i, o_valid); end
            if (o_mac !== 32'd0) begin n_errors++; $display("FAIL idle_mac cyc=%0d got=%0h want=0", i, o_mac); end
            if (o_ir !== 16'd0) begin n_errors++; $display("FAIL idle_ir cyc=%0d got=%0h want=0", i, o_ir); end
        end
    endtask

    task automatic test_dot_product();
        step(1, 4096 * 100, 1, 0, 0, 1, 0, 1);
        step(1, 4096 * 200, 0, 0, 0, 1, 0, 0);
        step(1, 4096 * 50,  0, 1, 1, 1, 0, 0);
        n_checks++;
        if (o_valid !== 1'b0) begin n_errors++; $display("FAIL dot_early_valid got=%0b want=0", o_valid); end
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_checks += 5;
        if (o_valid !== 1'b1) begin n_errors++; $display("FAIL dot_valid got=%0b want=1", o_valid); end
        if ($signed(o_mac) !== 32'sd250) begin n_errors++; $display("FAIL dot_mac got=%0d want=250", $signed(o_mac)); end
        if ($signed(o_ir) !== 16'sd250) begin n_errors++; $display("FAIL dot_ir got=%0d want=250", $signed(o_ir)); end
        if ({o_macOvfPos, o_macOvfNeg, o_irSat} !== 3'b000)
            begin n_errors++; $display("FAIL dot_flags got=%03b want=000", {o_macOvfPos, o_macOvfNeg, o_irSat}); end
        step(0, 0, 0, 0, 0, 1, 0, 0);
        if (o_valid !== 1'b0) begin n_errors++; $display("FAIL dot_pulse_width got=%0b want=0", o_valid); end
    endtask

    task automatic test_ir_clamp();
        step(1, 4096 * 40000, 1, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        n_checks += 4;
        if (o_valid !== 1'b1) begin n_errors++; $display("FAIL clamp_hi_valid got=%0b want=1", o_valid); end
        if ($signed(o_mac) !== 32'sd40000) begin n_errors++; $display("FAIL clamp_hi_mac got=%0d want=40000", $signed(o_mac)); end
        if ($signed(o_ir) !== 16'sd32767) begin n_errors++; $display("FAIL clamp_hi_ir got=%0d want=32767", $signed(o_ir)); end
        if (o_irSat !== 1'b1) begin n_errors++; $display("FAIL clamp_hi_sat got=%0b want=1", o_irSat); end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (o_irSat !== 1'b0) begin n_errors++; $display("FAIL clamp_clear_sat got=%0b want=0", o_irSat); end
        step(1, -4096 * 5, 1, 0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        n_checks += 3;
        if ($signed(o_mac) !== -32'sd5) begin n_errors++; $display("FAIL clamp_lo_mac got=%0d want=-5", $signed(o_mac)); end
        if ($signed(o_ir) !== 16'sd0) begin n_errors++; $display("FAIL clamp_lo_ir got=%0d want=0", $signed(o_ir)); end
        if (o_irSat !== 1'b1) begin n_errors++; $display("FAIL clamp_lo_sat got=%0b want=1", o_irSat); end
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_mac_ovf();
        longint big;
        big = 64'sd1 <<< 33;
        for (int i = 0; i < 1023; i++) step(1, big, i == 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (o_macOvfPos !== 1'b0) begin n_errors++; $display("FAIL ovf_pos_early got=%0b want=0", o_macOvfPos); end
        step(1, big, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (o_macOvfPos !== 1'b1) begin n_errors++; $display("FAIL ovf_pos got=%0b want=1", o_macOvfPos); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks += 3;
        // acc wrapped to -2^43: low 32 bits are 0 and IR clamps to -32768
        if (o_mac !== 32'd0) begin n_errors++; $display("FAIL ovf_wrap_mac got=%0h want=0", o_mac); end
        if ($signed(o_ir) !== -16'sd32768) begin n_errors++; $display("FAIL ovf_wrap_ir got=%0d want=-32768", $signed(o_ir)); end
        if (m_acc != ACC_MIN) begin n_errors++; $display("FAIL ovf_model_acc got=%0d want=%0d", m_acc, ACC_MIN); end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, (64'sd1 <<< 34) - 1, 0, 1, 0, 0, 0, 0);
        n_checks += 2;
        if (o_macOvfNeg !== 1'b1) begin n_errors++; $display("FAIL ovf_neg got=%0b want=1", o_macOvfNeg); end
        if (o_macOvfPos !== 1'b0) begin n_errors++; $display("FAIL ovf_neg_pos got=%0b want=0", o_macOvfPos); end
        // acc is now 2^43-2^34+2; adding 2^34-1 overflows positive while flags are being cleared
        step(1, (64'sd1 <<< 34) - 1, 0, 0, 0, 0, 0, 1);
        n_checks += 2;
        if (o_macOvfPos !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins got=%0b want=1", o_macOvfPos); end
        if (o_macOvfNeg !== 1'b0) begin n_errors++; $display("FAIL ovf_clr_neg got=%0b want=0", o_macOvfNeg); end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if ({o_macOvfPos, o_macOvfNeg} !== 2'b00)
            begin n_errors++; $display("FAIL ovf_clr_alone got=%02b want=00", {o_macOvfPos, o_macOvfNeg}); end
    endtask

    task automatic test_back_to_back();
        step(1, 3, 1, 0, 0, 0, 0, 1);
        step(1, 4, 0, 0, 1, 0, 0, 0);
        step(1, 5, 1, 0, 0, 0, 0, 0);
        n_checks += 3;
        if (o_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_a_valid got=%0b want=1", o_valid); end
        if ($signed(o_mac) !== 32'sd7) begin n_errors++; $display("FAIL b2b_a_mac got=%0d want=7", $signed(o_mac)); end
        if ($signed(o_ir) !== 16'sd7) begin n_errors++; $display("FAIL b2b_a_ir got=%0d want=7", $signed(o_ir)); end
        step(1, 12, 0, 1, 1, 0, 0, 0);
        n_checks += 2;
        if (o_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_gap_valid got=%0b want=0", o_valid); end
        if ($signed(o_mac) !== 32'sd7) begin n_errors++; $display("FAIL b2b_hold_mac got=%0d want=7", $signed(o_mac)); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks += 3;
        if (o_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_b_valid got=%0b want=1", o_valid); end
        if ($signed(o_mac) !== -32'sd7) begin n_errors++; $display("FAIL b2b_b_mac got=%0d want=-7", $signed(o_mac)); end
        if ($signed(o_ir) !== -16'sd7) begin n_errors++; $display("FAIL b2b_b_ir got=%0d want=-7", $signed(o_ir)); end
    endtask

    task automatic test_reset_mid();
        step(1, 1000, 1, 0, 0, 0, 0, 0);
        step(1, 2000, 0, 0, 1, 0, 0, 0);
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            n_checks += 2;
            if (o_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid cyc=%0d got=%0b want=0", i, o_valid); end
            if (o_mac !== 32'd0) begin n_errors++; $display("FAIL rstmid_mac cyc=%0d got=%0h want=0", i, o_mac); end
        end
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (o_mac !== 32'd0) begin n_errors++; $display("FAIL rstmid_acc got=%0d want=0", $signed(o_mac)); end
        step(1, 77, 1, 0, 0, 0, 0, 0);
        step(1, 10, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks += 2;
        if (o_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_next_valid got=%0b want=1", o_valid); end
        if ($signed(o_mac) !== 32'sd67) begin n_errors++; $display("FAIL rstmid_next_mac got=%0d want=67", $signed(o_mac)); end
    endtask

    task automatic test_random();
        int len;
        longint p;
        for (int c = 0; c < 40; c++) begin
            len = $urandom_range(1, 4);
            for (int t = 0; t < len; t++) begin
                p = longint'($urandom_range(0, 32'h3f_ffff)) - 64'sd2097152;
                if ($urandom_range(0, 1) == 1) p = p * 4096;
                step(1, p, t == 0, 1'($urandom), t == len - 1, 1'($urandom), 1'($urandom),
                     $urandom_range(0, 7) == 0);
                n_checks += 4;
                if (o_valid !== m_valid) begin n_errors++; $display("FAIL rnd_valid cmd=%0d got=%0b want=%0b", c, o_valid, m_valid); end
                if (o_mac !== m_mac) begin n_errors++; $display("FAIL rnd_mac cmd=%0d got=%0d want=%0d", c, $signed(o_mac), m_mac); end
                if (o_ir !== m_ir) begin n_errors++; $display("FAIL rnd_ir cmd=%0d got=%0d want=%0d", c, $signed(o_ir), m_ir); end
                if ({o_macOvfPos, o_macOvfNeg, o_irSat} !== {m_pos, m_neg, m_sat})
                    begin n_errors++; $display("FAIL rnd_flags cmd=%0d got=%03b want=%03b", c, {o_macOvfPos, o_macOvfNeg, o_irSat}, {m_pos, m_neg, m_sat}); end
            end
            if ($urandom_range(0, 1) == 1) begin
                step(0, 0, 0, 0, 0, 1'($urandom), 1'($urandom), 0);
                n_checks += 3;
                if (o_valid !== m_valid) begin n_errors++; $display("FAIL rnd_idle_valid cmd=%0d got=%0b want=%0b", c, o_valid, m_valid); end
                if (o_mac !== m_mac) begin n_errors++; $display("FAIL rnd_idle_mac cmd=%0d got=%0d want=%0d", c, $signed(o_mac), m_mac); end
                if (o_ir !== m_ir) begin n_errors++; $display("FAIL rnd_idle_ir cmd=%0d got=%0d want=%0d", c, $signed(o_ir), m_ir); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_dot_product();
        test_ir_clamp();
        test_mac_ovf();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gte_mac_accum.md
Name: gte_mac_accum

Overview:
- Single-lane multiply-accumulate and saturation stage for the GTE datapath. Three instances are used, one per unit 1..3.
- Consumes the signed 35-bit product from the operand-selection/multiplier stage directly upstream.
- Accumulates the terms of one command into a 44-bit MAC. On the last term it applies the shift and IR clamping, producing MACn, IRn and sticky FLAG bits.

Parameters:
- PROD_W, 35, width of incoming signed product.
- ACC_W, 44, accumulator width; MAC overflow is checked at this width.
- OUT_W, 32, width of the o_mac result.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  i_product is valid this cycle.
- i_product  in  35  signed product from the selection/multiplier stage.
- i_clear  in  1  first term: the accumulator is replaced, not added to. Qualified by i_valid.
- i_negate  in  1  subtract the product instead of adding it. Qualified by i_valid.
- i_last  in  1  final term of the command; starts the output stage. Qualified by i_valid.
- i_sf  in  1  shift the result right arithmetically by 12 at output.
- i_lm  in  1  IR lower clamp is 0 instead of -32768.
- i_flagClr  in  1  clear the sticky flags (command start).
- o_valid  out  1  one-cycle pulse: o_mac and o_ir have just been updated.
- o_mac  out  32  signed MACn result.
- o_ir  out  16  signed saturated IRn.
- o_macOvfPos  out  1  sticky: accumulator exceeded +2^43-1.
- o_macOvfNeg  out  1  sticky: accumulator went below -2^43.
- o_irSat  out  1  sticky: IR clamp was applied.

Behaviour:
- Reset (i_rst=1 at a clock edge): the accumulator, o_mac, o_ir, o_valid and all flags go to 0. This takes precedence over every other input, including mid-command; no partial result is emitted afterwards.
- Accumulate stage (edge ending cycle N, when i_valid=1):
  - term = i_negate ? -sext(i_product) : sext(i_product), sign-extended to ACC_W+1 = 45 bits.
  - base = i_clear ? 0 : acc.
  - sum = base + term, computed at 45 bits.
  - If sum > 2^43-1, set o_macOvfPos. If sum < -2^43, set o_macOvfNeg.
  - acc <= sum[43:0]: the stored value wraps in two's complement and is not saturated.
  - This check runs on every term, not only the last.
- i_valid=0: acc holds. i_clear, i_negate and i_last are ignored.
- Output stage (edge ending cycle N+1, after a cycle N with i_valid & i_last):
  - shifted = i_sf ? (acc >>> 12) : acc, arithmetic shift.
  - o_mac <= shifted[31:0], truncated.
  - lo = i_lm ? 0 : -32768; hi = 32767.
  - o_ir <= clamp(shifted, lo, hi). If the clamp changes the value, set o_irSat.
  - i_sf and i_lm are sampled in cycle N+1.
- o_valid is 1 during cycle N+2 only. Latency from the last term to result is 2 cycles.
- Back-to-back commands: a new i_clear term may arrive in cycle N+1. The output stage uses acc as committed at the end of cycle N, so the new term does not corrupt it.
- Flags:
  - Sticky until i_flagClr.
  - If i_flagClr and a set condition occur in the same cycle, the set wins (flag = 1).
  - i_flagClr alone: flags = 0 at the next edge.
- o_mac and o_ir hold their value between o_valid pulses.
- No backpressure exists. Upstream issues at most one term per cycle, and the consumer must take the result during the o_valid cycle.

Test Plan:
- Reset then idle: all outputs are 0. Drive i_valid=0 with random other inputs for 10 cycles -> outputs stay 0 and o_valid never rises.
- 3-term dot product: terms 4096*100, 4096*200, 4096*(-50) with clear/-/last; sf=1, lm=0 -> o_valid two cycles after the last term, o_mac=250, o_ir=250, no flags.
- IR clamp: single term 4096*40000 with clear and last, sf=1, lm=0 -> o_mac=40000, o_ir=32767, o_irSat=1. Repeat with product -4096*5 and lm=1 -> o_mac=-5, o_ir=0, o_irSat=1.
- MAC overflow:
  - Accumulate 2^33 (within the 35-bit signed product range) 1024 times so the sum reaches 2^43 -> o_macOvfPos=1 and acc wraps to -2^43.
  - A single subtract term (i_negate) of 2^34-1 applied to an acc of -2^43+1 -> o_macOvfNeg=1.
  - Assert i_flagClr in the same cycle as an overflowing term -> flag still 1. Assert it alone the next cycle -> flag 0.
- Back-to-back and negate: command A (last in cycle N, result 7) followed by command B with clear in cycle N+1 -> the A result (7) appears in N+2 uncorrupted, and the B result is correct. Verify i_negate of product 12 against acc 5 gives -7.
- Reset mid-command: assert i_rst between term 2 and term 3 -> acc=0, no o_valid pulse. The next command from clear produces a correct result.
